fifo_unpack_reader: RTL

- Drains a first-word-fall-through FIFO through its read side (read_en/empty) and breaks each wide word into narrower segments.
- Writes the segments into a downstream FIFO through its write side (write_en/full).
- Sits between a wide capture FIFO and a narrow serializer or output FIFO.
- One-word holding register plus a segment counter; full throughput when the downstream never asserts full.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/fifo_unpack_reader_if.sv | 27 ++
 rtl/srl_fifo_reg.sv | 50 +++++
 rtl/fifo_unpack_reader.sv | 97 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO width-conversion blocks.
//   clog2()           : ceiling log2, usable in localparam expressions
//   state_t           : holding-register state (EMPTY / EMIT)
//   FIFO_WIDTH_CHECK  : elaboration-time check that a wide word splits evenly

`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Fails elaboration when the wide word is not a whole number of segments.
`define FIFO_WIDTH_CHECK(iw, ow) \
    generate \
        if (((iw) % (ow)) != 0) begin : g_width_check \
            $error("IN_WIDTH must be an integer multiple of OUT_WIDTH"); \
        end \
    endgenerate

package fifo_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/fifo_unpack_reader_if.sv
// Handshake bundle for fifo_unpack_reader.
//   Upstream FWFT read side : in_data, in_last, in_empty, in_read_en
//   Downstream write side   : out_data, out_last, out_write_en, out_full
// master = the unpacker, slave = the FIFOs / environment around it.
interface fifo_unpack_reader_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 in_empty;
    logic                 in_read_en;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 out_write_en;
    logic                 out_full;

    modport master (
        input  in_data, in_last, in_empty, out_full,
        output in_read_en, out_data, out_last, out_write_en
    );

    modport slave (
        output in_data, in_last, in_empty, out_full,
        input  in_read_en, out_data, out_last, out_write_en
    );
endinterface

// File: rtl/srl_fifo_reg.sv
// Small first-word-fall-through register FIFO.
//   wr_en/wr_data/full : write side, write ignored when full
//   rd_en/rd_data/empty: read side, rd_data valid whenever empty=0
// DEPTH must be a power of two so the pointers wrap naturally.
module srl_fifo_reg
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      cnt_reg;
    logic             do_wr;
    logic             do_rd;

    assign full    = (cnt_reg == (AW+1)'(DEPTH));
    assign empty   = (cnt_reg == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_wr && !do_rd)      cnt_reg <= cnt_reg + (AW+1)'(1);
            else if (do_rd && !do_wr) cnt_reg <= cnt_reg - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/fifo_unpack_reader.sv
// Drains a wide FWFT FIFO and writes each word downstream as N narrower
// segments. A single holding register plus segment counter gives full
// throughput: the next word is popped in the same cycle the last segment
// of the current word is accepted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fifo_unpack_reader_if.master (upstream read + downstream write)
module fifo_unpack_reader
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_unpack_reader_if.master  bus
);
    `FIFO_WIDTH_CHECK(IN_WIDTH, OUT_WIDTH)

    localparam int N  = IN_WIDTH / OUT_WIDTH;
    localparam int CW = (clog2(N) > 1) ? clog2(N) : 1;

    state_t                state_reg, state_next;
    logic [IN_WIDTH-1:0]   hold_data_reg, hold_data_next;
    logic                  hold_last_reg, hold_last_next;
    logic [CW-1:0]         seg_cnt_reg, seg_cnt_next;

    logic                  hold_valid;
    logic                  last_seg;
    logic                  xfer;
    logic                  fin;
    logic                  pop;
    logic [OUT_WIDTH-1:0]  seg_arr [N];

    assign hold_valid = (state_reg == ST_EMIT);
    assign last_seg   = (seg_cnt_reg == CW'(N-1));
    assign xfer       = hold_valid & ~bus.out_full;
    assign fin        = xfer & last_seg;
    // Pop only from registered state and the FIFO flag, so there is no
    // combinational path from out_full into the upstream FIFO beyond fin.
    assign pop        = ~rst & ~bus.in_empty & (~hold_valid | fin);

    // Segment k of the held word, ordered by LSB_FIRST.
    for (genvar gi = 0; gi < N; gi++) begin : g_seg
        if (LSB_FIRST) begin : g_lsb
            assign seg_arr[gi] = hold_data_reg[gi*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_msb
            assign seg_arr[gi] = hold_data_reg[(N-1-gi)*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    assign bus.in_read_en   = pop;
    assign bus.out_write_en = hold_valid;
    assign bus.out_data     = seg_arr[seg_cnt_reg];
    assign bus.out_last     = hold_valid & hold_last_reg & last_seg;

    always_comb begin
        state_next     = state_reg;
        hold_data_next = hold_data_reg;
        hold_last_next = hold_last_reg;
        seg_cnt_next   = seg_cnt_reg;
        if (pop) begin
            // Also covers fin+pop: reload with no bubble between words.
            state_next     = ST_EMIT;
            hold_data_next = bus.in_data;
            hold_last_next = bus.in_last;
            seg_cnt_next   = '0;
        end else if (xfer) begin
            if (last_seg) begin
                state_next   = ST_EMPTY;
                seg_cnt_next = '0;
            end else begin
                seg_cnt_next = seg_cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // Data register needs no reset: it is only observed when valid.
        hold_data_reg <= hold_data_next;
        if (rst) begin
            state_reg     <= ST_EMPTY;
            hold_last_reg <= 1'b0;
            seg_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            hold_last_reg <= hold_last_next;
            seg_cnt_reg   <= seg_cnt_next;
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.out_write_en && bus.out_full) |=> $stable(bus.out_data));

    a_no_pop_empty: assert property (@(posedge clk)
        bus.in_read_en |-> !bus.in_empty);
endmodule
